mux_scan_ctrl: RTL

Sequencing stage that sits directly upstream of the 4:1 `mux` block. It drives the mux select `s`, walks it through channels 0..3, and holds each channel for a programmable dwell time. At the end of each dwell it samples the mux output `out_a`, returned here as `mux_out`. A complete scan produces a 4-bit snapshot of in_a..in_d with a start/done handshake.

---
 rtl/mux_scan_pkg.sv | 19 +
 rtl/scan_dwell_cnt.sv | 40 ++++
 rtl/mux_scan_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan sequencer.
// Optional continuous scanning is enabled with MUX_SCAN_CONT_EN.
package mux_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_e;

  // Dwell counter width; a single-cycle dwell still needs one bit.
  function automatic int cnt_w(input int dwell);
    return (dwell > 1) ? $clog2(dwell) : 1;
  endfunction

endpackage

// File: rtl/scan_dwell_cnt.sv
// Dwell counter: counts 0..DWELL-1 while enabled, flags the last cycle.
// Part of mux_scan_ctrl (MUX_SCAN_CONT_EN has no effect here).
module scan_dwell_cnt
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = cnt_w(DWELL);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Walks a 4:1 mux select through all channels and snapshots its output.
// Define MUX_SCAN_CONT_EN to rescan continuously after the first start.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mux_out,
  output logic [SEL_W-1:0]  s,
  output logic              busy,
  output logic              done,
  output logic [NUM_CH-1:0] sample
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  scan_state_e       state_q;
  scan_state_e       state_d;
  logic [SEL_W-1:0]  ch_q;
  logic [SEL_W-1:0]  ch_d;
  logic [NUM_CH-1:0] sample_q;
  logic [NUM_CH-1:0] sample_d;
  logic              busy_q;
  logic              busy_d;
  logic              done_q;
  logic              done_d;

  logic tick;
  logic cnt_en;
  logic cnt_clr;

  assign cnt_en  = (state_q == SCAN);
  assign cnt_clr = !cnt_en;

  scan_dwell_cnt #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tick(tick)
  );

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    sample_d = sample_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SCAN;
          ch_d     = '0;
          sample_d = '0;
        end
      end
      SCAN: begin
        // Capture on the last dwell cycle, once the mux has settled.
        if (tick) begin
          sample_d[ch_q] = mux_out;
          if (ch_q == LAST_CH) begin
            state_d = DONE;
          end else begin
            ch_d = ch_q + SEL_W'(1);
          end
        end
      end
      DONE: begin
`ifdef MUX_SCAN_CONT_EN
        state_d = SCAN;
        ch_d    = '0;
`else
        state_d = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      sample_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign s      = ch_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign sample = sample_q;

endmodule
